// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART host command processor: the opcodes the
// host may send, the single response byte returned for each command, the
// parser state encoding and the number of argument bytes each opcode carries.
package uart_cmd_pkg;

   // Host opcodes. 0x22 and 0x01 are the legacy single-byte commands kept so
   // existing host scripts keep working; 0x30/0x31 are the multi-byte forms.
   localparam logic [7:0] OP_APU_RESET      = 8'h22;
   localparam logic [7:0] OP_AUDIO_RESET    = 8'h01;
   localparam logic [7:0] OP_MASK_RESET     = 8'h30;
   localparam logic [7:0] OP_MASK_LEN_RESET = 8'h31;
   localparam logic [7:0] OP_DROP_COUNT     = 8'h7E;
   localparam logic [7:0] OP_PING           = 8'h7F;

   // Response bytes sent back to the host, one per command.
   localparam logic [7:0] RSP_ACK  = 8'h06;
   localparam logic [7:0] RSP_NAK  = 8'h15;
   localparam logic [7:0] RSP_PING = 8'hA5;

   // Parser states: waiting for an opcode, collecting argument bytes,
   // driving the reset pulse, and waiting for the host to take the response.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARGS    = 2'd1,
      PULSE   = 2'd2,
      RESPOND = 2'd3
   } cmdState_t;

   // Number of argument bytes that follow an opcode. Opcodes that need no
   // arguments (including unknown ones) return zero.
   function automatic logic [1:0] argCount(input logic [7:0] opcode);
      case (opcode)
         OP_MASK_RESET:     argCount = 2'd1;
         OP_MASK_LEN_RESET: argCount = 2'd3;
         default:           argCount = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/uart_cmd_pulse_timer.sv
// Reset pulse generator. A one-cycle load captures the channel mask and the
// pulse length; the mask appears on reset_out on the following cycle and is
// held for exactly len cycles by a down-counter. reset_out comes straight
// from flops so downstream reset domains never see a combinational glitch.
module uart_cmd_pulse_timer
   import uart_cmd_pkg::*;
#(
   parameter int NUM_CHANNELS = 2,
   parameter int CNT_W        = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    load,
   input  logic [CNT_W-1:0]        len,
   input  logic [NUM_CHANNELS-1:0] mask,
   output logic [NUM_CHANNELS-1:0] reset_out,
   output logic                    done
);

   logic [CNT_W-1:0] remaining;

   // The counter holds the number of high cycles still to go, including the
   // current one. When it is about to run out the outputs are cleared on the
   // same edge that the counter reaches zero, so the pulse is exactly len
   // cycles wide. The async reset drops reset_out immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         remaining <= '0;
         reset_out <= '0;
      end else if (load) begin
         remaining <= len;
         reset_out <= mask;
      end else if (remaining != '0) begin
         remaining <= remaining - CNT_W'(1);
         if (remaining == CNT_W'(1)) begin
            reset_out <= '0;
         end
      end
   end

   // Done flags the final high cycle so the parser can move on in lockstep
   // with the pulse ending.
   assign done = (remaining == CNT_W'(1));

endmodule

// File: rtl/uart_cmd_processor.sv
// Host command processor between the UART and the APU/audio reset domains.
// Parses single- and multi-byte host commands, fires programmable-width
// reset pulses on NUM_CHANNELS outputs and returns exactly one response
// byte per command over a valid/ready transmit interface. Bytes arriving
// while a pulse or response is in flight are dropped and counted.
module uart_cmd_processor
   import uart_cmd_pkg::*;
#(
   parameter int NUM_CHANNELS   = 2,
   parameter int PULSE_CYCLES   = 200000,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int CNT_W          = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [7:0]              in_uart_byte,
   input  logic                    in_uart_byte_ready,
   output logic [7:0]              out_uart_byte,
   output logic                    out_uart_byte_valid,
   input  logic                    out_uart_byte_ready,
   output logic [NUM_CHANNELS-1:0] reset_out,
   output logic                    busy
);

   localparam logic [CNT_W-1:0] DEFAULT_LEN  = CNT_W'(PULSE_CYCLES);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   cmdState_t state;
   cmdState_t nextState;

   logic [1:0]              argsNeeded;
   logic [1:0]              argIdx;
   logic [7:0]              argMask;
   logic [7:0]              argLenHi;
   logic [CNT_W-1:0]        idleCount;
   logic [7:0]              respByte;
   logic [7:0]              dropCount;
   logic                    clearDropPending;

   logic                    timerLoad;
   logic [NUM_CHANNELS-1:0] timerMask;
   logic [CNT_W-1:0]        timerLen;
   logic                    timerDone;
   logic                    respLoad;
   logic [7:0]              respNext;
   logic                    dropQuery;
   logic [7:0]              candMask;
   logic [CNT_W-1:0]        candLen;
   logic                    lastArg;
   logic                    handshake;
   logic                    dropStrobe;

   // A mask is usable only if it selects at least one channel and every
   // selected channel actually exists on this instance.
   function automatic logic maskIsValid(input logic [7:0] m);
      logic ok;
      ok = (m != 8'h00);
      for (int i = NUM_CHANNELS; i < 8; i++) begin
         if (m[i]) begin
            ok = 1'b0;
         end
      end
      return ok;
   endfunction

   // Parser state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Candidate mask/length as they will look once the byte arriving now is
   // stored. Only meaningful on the final argument byte, where the command is
   // validated without waiting an extra cycle for the byte to land.
   always_comb begin
      candMask = argMask;
      candLen  = DEFAULT_LEN;
      if (argIdx == 2'd0) begin
         candMask = in_uart_byte;
      end
      if (argsNeeded == 2'd3) begin
         candLen = CNT_W'({argLenHi, in_uart_byte});
      end
      lastArg = (argIdx == (argsNeeded - 2'd1));
   end

   // Next-state and command decode. A strobe in ARGS takes priority over a
   // timeout expiring in the same cycle, which falls out of checking the
   // strobe first. The response byte and the timer load are produced here
   // and captured by the registers below.
   always_comb begin
      nextState = state;
      timerLoad = 1'b0;
      timerMask = '0;
      timerLen  = DEFAULT_LEN;
      respLoad  = 1'b0;
      respNext  = RSP_NAK;
      dropQuery = 1'b0;
      case (state)
         IDLE: begin
            if (in_uart_byte_ready) begin
               case (in_uart_byte)
                  OP_APU_RESET: begin
                     timerLoad = 1'b1;
                     timerMask = NUM_CHANNELS'(1);
                     nextState = PULSE;
                  end
                  OP_AUDIO_RESET: begin
                     if (NUM_CHANNELS >= 2) begin
                        timerLoad = 1'b1;
                        timerMask = NUM_CHANNELS'(2);
                        nextState = PULSE;
                     end else begin
                        respLoad  = 1'b1;
                        respNext  = RSP_NAK;
                        nextState = RESPOND;
                     end
                  end
                  OP_MASK_RESET, OP_MASK_LEN_RESET: begin
                     nextState = ARGS;
                  end
                  OP_DROP_COUNT: begin
                     respLoad  = 1'b1;
                     respNext  = dropCount;
                     dropQuery = 1'b1;
                     nextState = RESPOND;
                  end
                  OP_PING: begin
                     respLoad  = 1'b1;
                     respNext  = RSP_PING;
                     nextState = RESPOND;
                  end
                  default: begin
                     respLoad  = 1'b1;
                     respNext  = RSP_NAK;
                     nextState = RESPOND;
                  end
               endcase
            end
         end
         ARGS: begin
            if (in_uart_byte_ready) begin
               if (lastArg) begin
                  if (maskIsValid(candMask) && (candLen != '0)) begin
                     timerLoad = 1'b1;
                     timerMask = candMask[NUM_CHANNELS-1:0];
                     timerLen  = candLen;
                     nextState = PULSE;
                  end else begin
                     respLoad  = 1'b1;
                     respNext  = RSP_NAK;
                     nextState = RESPOND;
                  end
               end
            end else if (idleCount == TIMEOUT_LAST) begin
               respLoad  = 1'b1;
               respNext  = RSP_NAK;
               nextState = RESPOND;
            end
         end
         PULSE: begin
            if (timerDone) begin
               respLoad  = 1'b1;
               respNext  = RSP_ACK;
               nextState = RESPOND;
            end
         end
         RESPOND: begin
            if (out_uart_byte_ready) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Argument capture. The opcode's argument count is latched in IDLE and the
   // bytes are stored in arrival order: mask first, then length high/low.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         argsNeeded <= 2'd0;
         argIdx     <= 2'd0;
         argMask    <= 8'h00;
         argLenHi   <= 8'h00;
      end else if (state == IDLE && in_uart_byte_ready) begin
         argsNeeded <= argCount(in_uart_byte);
         argIdx     <= 2'd0;
      end else if (state == ARGS && in_uart_byte_ready) begin
         if (argIdx == 2'd0) begin
            argMask <= in_uart_byte;
         end
         if (argIdx == 2'd1) begin
            argLenHi <= in_uart_byte;
         end
         argIdx <= argIdx + 2'd1;
      end
   end

   // Inter-byte timeout: counts idle cycles while collecting arguments and
   // restarts on every received byte, so only a gap aborts the command.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idleCount <= '0;
      end else if (state != ARGS || in_uart_byte_ready) begin
         idleCount <= '0;
      end else begin
         idleCount <= idleCount + CNT_W'(1);
      end
   end

   // Response byte register. It only changes when a new response is chosen,
   // so the byte stays stable for as long as the host holds off ready.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         respByte <= 8'h00;
      end else if (respLoad) begin
         respByte <= respNext;
      end
   end

   assign handshake  = (state == RESPOND) && out_uart_byte_ready;
   assign dropStrobe = in_uart_byte_ready && (state == PULSE || state == RESPOND);

   // Dropped-byte counter. It saturates rather than wrapping so the host can
   // tell "lots" from "few". A drop-count query clears it only once the host
   // has actually taken the answer; a byte dropped in that same handshake
   // cycle is still counted against the fresh total.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dropCount        <= 8'h00;
         clearDropPending <= 1'b0;
      end else begin
         if (dropQuery) begin
            clearDropPending <= 1'b1;
         end else if (handshake) begin
            clearDropPending <= 1'b0;
         end
         if (handshake && clearDropPending) begin
            dropCount <= dropStrobe ? 8'h01 : 8'h00;
         end else if (dropStrobe && dropCount != 8'hFF) begin
            dropCount <= dropCount + 8'h01;
         end
      end
   end

   uart_cmd_pulse_timer #(
      .NUM_CHANNELS(NUM_CHANNELS),
      .CNT_W       (CNT_W)
   ) pulseTimer (
      .clock    (clock),
      .reset    (reset),
      .load     (timerLoad),
      .len      (timerLen),
      .mask     (timerMask),
      .reset_out(reset_out),
      .done     (timerDone)
   );

   assign out_uart_byte       = respByte;
   assign out_uart_byte_valid = (state == RESPOND);
   assign busy                = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_processor.sv
// Bench for the UART command processor. Stimulus pushes the response byte
// each command should produce into a queue; an independent monitor pops and
// compares whenever the DUT completes a TX handshake. Pulse width, timeout
// timing, back-pressure, drop counting and mid-pulse reset are checked from
// the stimulus thread. Short pulse/timeout parameters keep the run brief.
module tb_uart_cmd_processor;

   localparam int NUM_CH  = 2;
   localparam int PULSE   = 20;
   localparam int TIMEOUT = 100;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [7:0]        rxByte = 8'h00;
   logic              rxStrobe = 1'b0;
   logic [7:0]        txByte;
   logic              txValid;
   logic              txReady = 1'b1;
   logic [NUM_CH-1:0] resetOut;
   logic              busy;

   logic [7:0] expectQ[$];
   int checks = 0;
   int failures = 0;

   uart_cmd_processor #(
      .NUM_CHANNELS  (NUM_CH),
      .PULSE_CYCLES  (PULSE),
      .TIMEOUT_CYCLES(TIMEOUT),
      .CNT_W         (32)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .in_uart_byte       (rxByte),
      .in_uart_byte_ready (rxStrobe),
      .out_uart_byte      (txByte),
      .out_uart_byte_valid(txValid),
      .out_uart_byte_ready(txReady),
      .reset_out          (resetOut),
      .busy               (busy)
   );

   // Free-running clock.
   always #5 clock = ~clock;

   // Single comparison point: every check counts, mismatches print FAIL.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Drive one byte as a single-cycle strobe, changing inputs just after the
   // rising edge so the DUT samples it cleanly on the next edge.
   task automatic applyStimulus(input logic [7:0] b);
      @(posedge clock);
      #1;
      rxByte   = b;
      rxStrobe = 1'b1;
      @(posedge clock);
      #1;
      rxStrobe = 1'b0;
   endtask

   // Watch a pulse that should start on the first cycle after the strobe
   // and last exactly len cycles with busy held high throughout.
   task automatic measurePulse(input string name, input logic [NUM_CH-1:0] mask, input int len);
      int highCycles;
      logic busyDropped;
      highCycles  = 0;
      busyDropped = 1'b0;
      @(negedge clock);
      checkOutput({name, "Start"}, 32'(resetOut), 32'(mask));
      for (int i = 0; i < len + 20; i++) begin
         if (resetOut != mask) break;
         highCycles++;
         if (!busy) busyDropped = 1'b1;
         @(negedge clock);
      end
      checkOutput({name, "Width"}, 32'(highCycles), 32'(len));
      checkOutput({name, "Busy"}, 32'(busyDropped), 32'd0);
      checkOutput({name, "After"}, 32'(resetOut), 32'd0);
   endtask

   // Wait, with a bound, until the DUT is idle and every expected response
   // has been consumed; also reports any reset_out activity seen meanwhile.
   task automatic waitIdle(input string name, output logic [NUM_CH-1:0] seenReset);
      logic reached;
      reached   = 1'b0;
      seenReset = '0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clock);
         seenReset = seenReset | resetOut;
         if (!busy && !txValid && expectQ.size() == 0) begin
            reached = 1'b1;
            break;
         end
      end
      checkOutput({name, "Idle"}, 32'(reached), 32'd1);
   endtask

   // Monitor: a handshake happens on the next rising edge whenever valid and
   // ready are both high at the falling edge, so that is where responses are
   // scored against the queue.
   always @(negedge clock) begin
      if (!reset && txValid && txReady) begin
         if (expectQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpectedResponse: got %02h, expected no response", txByte);
         end else begin
            checkOutput("responseByte", 32'(txByte), 32'(expectQ.pop_front()));
         end
      end
   end

   // Safety net so a stuck design can never hang the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, failures=%0d", failures);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed command sequence.
   initial begin
      logic [NUM_CH-1:0] seen;
      int badSamples;

      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("resetResetOut", 32'(resetOut), 32'd0);
      checkOutput("resetValid", 32'(txValid), 32'd0);
      checkOutput("resetByte", 32'(txByte), 32'd0);
      checkOutput("resetBusy", 32'(busy), 32'd0);
      @(posedge clock);
      #1 reset = 1'b0;

      $display("[TB] legacy APU reset 0x22");
      expectQ.push_back(8'h06);
      applyStimulus(8'h22);
      measurePulse("legacyApu", 2'b01, PULSE);
      waitIdle("legacyApu", seen);

      $display("[TB] legacy audio reset 0x01");
      expectQ.push_back(8'h06);
      applyStimulus(8'h01);
      measurePulse("legacyAudio", 2'b10, PULSE);
      waitIdle("legacyAudio", seen);

      $display("[TB] mask+length 0x31 03 00 10");
      expectQ.push_back(8'h06);
      applyStimulus(8'h31);
      applyStimulus(8'h03);
      applyStimulus(8'h00);
      applyStimulus(8'h10);
      measurePulse("maskLen", 2'b11, 16);
      waitIdle("maskLen", seen);

      $display("[TB] out-of-range mask 0x31 04 00 10");
      expectQ.push_back(8'h15);
      applyStimulus(8'h31);
      applyStimulus(8'h04);
      applyStimulus(8'h00);
      applyStimulus(8'h10);
      waitIdle("badMask", seen);
      checkOutput("badMaskNoPulse", 32'(seen), 32'd0);

      $display("[TB] zero length and zero mask");
      expectQ.push_back(8'h15);
      applyStimulus(8'h31);
      applyStimulus(8'h01);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      waitIdle("zeroLen", seen);
      checkOutput("zeroLenNoPulse", 32'(seen), 32'd0);
      expectQ.push_back(8'h15);
      applyStimulus(8'h30);
      applyStimulus(8'h00);
      waitIdle("zeroMask", seen);
      checkOutput("zeroMaskNoPulse", 32'(seen), 32'd0);

      $display("[TB] unknown opcode");
      expectQ.push_back(8'h15);
      applyStimulus(8'h99);
      waitIdle("unknownOp", seen);

      $display("[TB] argument timeout then ping");
      expectQ.push_back(8'h15);
      applyStimulus(8'h30);
      badSamples = 0;
      for (int i = 0; i < TIMEOUT; i++) begin
         @(negedge clock);
         if (txValid) badSamples++;
      end
      checkOutput("timeoutNotEarly", 32'(badSamples), 32'd0);
      @(negedge clock);
      checkOutput("timeoutNakOnTime", 32'(txValid), 32'd1);
      waitIdle("timeout", seen);
      expectQ.push_back(8'hA5);
      applyStimulus(8'h7F);
      waitIdle("ping", seen);

      $display("[TB] back-pressure on TX");
      @(posedge clock);
      #1 txReady = 1'b0;
      expectQ.push_back(8'hA5);
      applyStimulus(8'h7F);
      badSamples = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (!txValid || txByte != 8'hA5) badSamples++;
      end
      checkOutput("heldValidStable", 32'(badSamples), 32'd0);
      @(posedge clock);
      #1 txReady = 1'b1;
      @(negedge clock);
      @(negedge clock);
      checkOutput("acceptedFirstReady", 32'(expectQ.size()), 32'd0);
      checkOutput("validDropsAfterAccept", 32'(txValid), 32'd0);

      $display("[TB] drop counting");
      expectQ.push_back(8'h06);
      applyStimulus(8'h22);
      applyStimulus(8'h55);
      applyStimulus(8'h56);
      applyStimulus(8'h57);
      waitIdle("dropPulse", seen);
      expectQ.push_back(8'h03);
      applyStimulus(8'h7E);
      waitIdle("dropQuery1", seen);
      expectQ.push_back(8'h00);
      applyStimulus(8'h7E);
      waitIdle("dropQuery2", seen);

      $display("[TB] reset in the middle of a pulse");
      applyStimulus(8'h31);
      applyStimulus(8'h03);
      applyStimulus(8'h00);
      applyStimulus(8'h40);
      repeat (10) @(negedge clock);
      checkOutput("midPulseHigh", 32'(resetOut), 32'd3);
      @(posedge clock);
      #1 reset = 1'b1;
      #1;
      checkOutput("resetDropsPulse", 32'(resetOut), 32'd0);
      checkOutput("resetClearsBusy", 32'(busy), 32'd0);
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      badSamples = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (txValid || busy || resetOut != '0) badSamples++;
      end
      checkOutput("quietAfterReset", 32'(badSamples), 32'd0);
      checkOutput("queueDrained", 32'(expectQ.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
